// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: operation controls from the master, register taps back from the slave.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic             En;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] D;
  logic             SIn;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] not_Q;
  logic             SOutL;
  logic             SOutR;
  logic             Wrap;

  modport master (
    output En, Mode, D, SIn,
    input  Q, not_Q, SOutL, SOutR, Wrap
  );

  modport slave (
    input  En, Mode, D, SIn,
    output Q, not_Q, SOutL, SOutR, Wrap
  );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: load, shift, rotate, clear, invert, with a complementary output
// and a one-cycle Wrap pulse after each complete WIDTH-step shift sequence.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  univ_shift_reg_if.slave  bus
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_INV   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             counted;

  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    counted = 1'b0;
    if (bus.En) begin
      case (mode_e'(bus.Mode))
        MODE_LOAD: begin
          q_d   = bus.D;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d     = {q_q[WIDTH-2:0], bus.SIn};
          counted = 1'b1;
        end
        MODE_SHR: begin
          q_d     = {bus.SIn, q_q[WIDTH-1:1]};
          counted = 1'b1;
        end
        MODE_ROTL: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          counted = 1'b1;
        end
        MODE_ROTR: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          counted = 1'b1;
        end
        MODE_CLEAR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        MODE_INV:  q_d = ~q_q;
        default:   q_d = q_q;
      endcase
    end
    // Every direction shares one counter; the WIDTH-th counted step wraps it.
    if (counted) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.not_Q = ~q_q;
  assign bus.SOutL = q_q[WIDTH-1];
  assign bus.SOutR = q_q[0];
  assign bus.Wrap  = wrap_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: an 8-bit instance (RESET_VAL=A5) and a 2-bit instance.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_on = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(8)) b8 ();
  univ_shift_reg_if #(.WIDTH(2)) b2 ();

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  univ_shift_reg #(.WIDTH(2), .RESET_VAL(2'b01)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Complement pair and serial taps, sampled on the falling edge every cycle once reset is done.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("notq8", {24'h0, b8.not_Q}, {24'h0, ~b8.Q});
      chk("notq2", {30'h0, b2.not_Q}, {30'h0, ~b2.Q});
      chk("soutl8", {31'h0, b8.SOutL}, {31'h0, b8.Q[7]});
      chk("soutr8", {31'h0, b8.SOutR}, {31'h0, b8.Q[0]});
    end
  end

  task automatic step8(input logic en, input logic [2:0] mode, input logic [7:0] d, input logic sin);
    b8.En = en; b8.Mode = mode; b8.D = d; b8.SIn = sin;
    @(posedge clk);
    #1;
  endtask

  task automatic exp8(input string tag, input logic [7:0] q, input logic wrap);
    chk({tag, "_q"}, {24'h0, b8.Q}, {24'h0, q});
    chk({tag, "_wrap"}, {31'h0, b8.Wrap}, {31'h0, wrap});
  endtask

  initial begin
    logic [7:0] sin_pat;
    logic [7:0] shl_exp [8];
    logic [7:0] rot_exp [5];
    logic [7:0] rr_exp  [8];

    b8.En = 1'b0; b8.Mode = 3'b000; b8.D = '0; b8.SIn = 1'b0;
    b2.En = 1'b0; b2.Mode = 3'b000; b2.D = '0; b2.SIn = 1'b0;

    // Reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    exp8("reset", 8'hA5, 1'b0);
    chk("reset_notq", {24'h0, b8.not_Q}, 32'h5A);
    chk("reset2_q", {30'h0, b2.Q}, 32'h1);
    chk("reset2_wrap", {31'h0, b2.Wrap}, 32'h0);

    // Load and clear
    step8(1'b1, 3'b001, 8'h3C, 1'b0);
    exp8("load", 8'h3C, 1'b0);
    chk("load_notq", {24'h0, b8.not_Q}, 32'hC3);
    step8(1'b1, 3'b110, 8'hFF, 1'b1);
    exp8("clear", 8'h00, 1'b0);

    // Serial-in conversion, pattern 1,0,1,1,0,0,1,0
    sin_pat = 8'b1011_0010;
    shl_exp = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 3'b010, 8'h00, sin_pat[7-i]);
      exp8($sformatf("shl%0d", i), shl_exp[i], (i == 7));
      chk($sformatf("shl%0d_soutl", i), {31'h0, b8.SOutL}, {31'h0, shl_exp[i][7]});
    end
    step8(1'b1, 3'b000, 8'h00, 1'b0);
    exp8("hold_after_wrap", 8'hB2, 1'b0);

    // Rotate, invert, rotate to wrap
    step8(1'b1, 3'b001, 8'h81, 1'b0);
    exp8("load81", 8'h81, 1'b0);
    step8(1'b1, 3'b101, 8'h00, 1'b0);
    exp8("rotr", 8'hC0, 1'b0);
    step8(1'b1, 3'b100, 8'h00, 1'b0);
    exp8("rotl1", 8'h81, 1'b0);
    step8(1'b1, 3'b100, 8'h00, 1'b0);
    exp8("rotl2", 8'h03, 1'b0);
    step8(1'b1, 3'b111, 8'h00, 1'b0);
    exp8("invert", 8'hFC, 1'b0);
    rot_exp = '{8'hF9, 8'hF3, 8'hE7, 8'hCF, 8'h9F};
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, 3'b100, 8'h00, 1'b0);
      exp8($sformatf("rot%0d", i), rot_exp[i], (i == 4));
    end

    // En gating
    for (int i = 0; i < 3; i++) begin
      step8(1'b0, 3'b001, 8'hFF, 1'b0);
      exp8($sformatf("en0_%0d", i), 8'h9F, 1'b0);
    end
    step8(1'b1, 3'b001, 8'h00, 1'b0);
    exp8("load00", 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step8(1'b1, 3'b010, 8'h00, 1'b1);
      exp8($sformatf("gA%0d", i), 8'((16'h1 << (i + 1)) - 1), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step8(1'b0, 3'b010, 8'h00, 1'b1);
      exp8($sformatf("gidle%0d", i), 8'h0F, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step8(1'b1, 3'b010, 8'h00, 1'b1);
      exp8($sformatf("gB%0d", i), 8'((16'h1 << (i + 5)) - 1), (i == 3));
    end

    // Reset mid-sequence
    step8(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step8(1'b1, 3'b010, 8'h00, 1'b0);
    exp8("pre_rst", 8'h00, 1'b0);
    b8.En = 1'b1; b8.Mode = 3'b001; b8.D = 8'h77;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp8("mid_rst", 8'hA5, 1'b0);
    rr_exp = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 3'b011, 8'h00, 1'b0);
      exp8($sformatf("shr%0d", i), rr_exp[i], (i == 7));
    end

    // WIDTH=2 instance: continuous shift right, Wrap every second cycle
    b8.En = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b2.En = 1'b1; b2.Mode = 3'b011; b2.SIn = ~i[0];
      @(posedge clk);
      #1;
      chk($sformatf("w2_q%0d", i), {30'h0, b2.Q}, (i % 2 == 0) ? 32'h2 : 32'h1);
      chk($sformatf("w2_wrap%0d", i), {31'h0, b2.Wrap}, {31'h0, (i % 2 == 1)});
    end
    b2.En = 1'b0;
    @(posedge clk);
    #1;
    chk("w2_wrap_idle", {31'h0, b2.Wrap}, 32'h0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
